// File: rtl/npc_pipe_if.sv
// Signal bundle between the fetch-stage next-PC unit and its D-stage/IMEM neighbours.
// slave = the PC unit itself; master = whatever drives the D-stage side (core or bench).
interface npc_pipe_if;
  logic        stall;
  logic [2:0]  npc_op;
  logic [2:0]  cmp_mode;
  logic [31:0] d_pc;
  logic [25:0] imm26;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic        taken;
  logic        pc_misaligned;

  modport slave (
    input  stall, npc_op, cmp_mode, d_pc, imm26, rs_val, rt_val, exc_req, eret, epc,
    output pc, link_pc, taken, pc_misaligned
  );

  modport master (
    output stall, npc_op, cmp_mode, d_pc, imm26, rs_val, rt_val, exc_req, eret, epc,
    input  pc, link_pc, taken, pc_misaligned
  );
endinterface

// File: rtl/npc_pipe.sv
// F-stage PC register and next-PC selection for the pipelined MIPS core:
// delayed-branch redirects from D, stall hold, exception vector entry and ERET return.
module npc_pipe #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter bit          ENABLE_EXC = 1'b1
) (
  input logic        clk,
  input logic        reset,
  npc_pipe_if.slave  bus
);

  localparam logic [2:0] OP_SEQ = 3'b000;
  localparam logic [2:0] OP_BR  = 3'b001;
  localparam logic [2:0] OP_J   = 3'b010;
  localparam logic [2:0] OP_JR  = 3'b011;

  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LEZ = 3'b010;
  localparam logic [2:0] CMP_GTZ = 3'b011;
  localparam logic [2:0] CMP_LTZ = 3'b100;
  localparam logic [2:0] CMP_GEZ = 3'b101;

  logic [31:0] pc_q, pc_d;
  logic        misaligned_q, misaligned_d;

  logic        exc_en, eret_en;
  logic        rs_zero, rs_neg;
  logic        cond;
  logic        taken_c;
  logic [31:0] d_pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] target;

  // Exception inputs are forced low when the exception path is compiled out.
  assign exc_en  = ENABLE_EXC ? bus.exc_req : 1'b0;
  assign eret_en = ENABLE_EXC ? bus.eret    : 1'b0;

  assign rs_zero    = (bus.rs_val == 32'd0);
  assign rs_neg     = bus.rs_val[31];
  assign d_pc_plus4 = bus.d_pc + 32'd4;
  assign br_offset  = {{14{bus.imm26[15]}}, bus.imm26[15:0], 2'b00};

  always_comb begin
    cond = 1'b0;
    case (bus.cmp_mode)
      CMP_EQ:  cond = (bus.rs_val == bus.rt_val);
      CMP_NE:  cond = (bus.rs_val != bus.rt_val);
      CMP_LEZ: cond = rs_neg | rs_zero;
      CMP_GTZ: cond = ~rs_neg & ~rs_zero;
      CMP_LTZ: cond = rs_neg;
      CMP_GEZ: cond = ~rs_neg;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    taken_c = 1'b0;
    target  = d_pc_plus4;
    case (bus.npc_op)
      OP_BR: begin
        taken_c = cond;
        target  = d_pc_plus4 + br_offset;
      end
      OP_J: begin
        taken_c = 1'b1;
        target  = {d_pc_plus4[31:28], bus.imm26, 2'b00};
      end
      OP_JR: begin
        taken_c = 1'b1;
        target  = bus.rs_val;
      end
      OP_SEQ:  taken_c = 1'b0;
      default: taken_c = 1'b0;
    endcase
  end

  // Priority: exception, ERET, stall hold, redirect, sequential (reset handled in the register).
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (exc_en) begin
      pc_d = EXC_VECTOR;
    end else if (eret_en) begin
      pc_d = bus.epc;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (taken_c) begin
      pc_d = target;
    end
    misaligned_d = (pc_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      misaligned_q <= (RESET_PC[1:0] != 2'b00);
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_misaligned = misaligned_q;
  assign bus.taken         = taken_c;
  assign bus.link_pc       = bus.d_pc + 32'd8;

endmodule

// File: tb/tb_npc_pipe.sv
// Directed bench for npc_pipe: reset, branches, jumps, compare modes, stall,
// exception/ERET priority and PC wrap, all against hand-computed values.
module tb_npc_pipe;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  npc_pipe_if bus ();

  npc_pipe #(
    .RESET_PC   (32'h0000_3000),
    .EXC_VECTOR (32'h0000_4180),
    .ENABLE_EXC (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    bus.stall    = 1'b0;
    bus.npc_op   = 3'b000;
    bus.cmp_mode = 3'b000;
    bus.d_pc     = 32'd0;
    bus.imm26    = 26'd0;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
    bus.exc_req  = 1'b0;
    bus.eret     = 1'b0;
    bus.epc      = 32'd0;
  endtask

  task automatic drive_branch(input logic [2:0] mode, input logic [31:0] dpc,
                              input logic [15:0] imm16, input logic [31:0] rs,
                              input logic [31:0] rt);
    bus.npc_op   = 3'b001;
    bus.cmp_mode = mode;
    bus.d_pc     = dpc;
    bus.imm26    = {10'd0, imm16};
    bus.rs_val   = rs;
    bus.rt_val   = rt;
  endtask

  task automatic cmp_taken(input string tag, input logic [2:0] mode,
                           input logic [31:0] rs, input logic exp);
    drive_branch(mode, 32'h3004, 16'h0001, rs, 32'd0);
    #1;
    check(tag, {31'd0, bus.taken}, {31'd0, exp});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    check("reset_pc", bus.pc, 32'h3000);
    check("reset_mis", {31'd0, bus.pc_misaligned}, 32'd0);
    reset = 1'b0;

    tick(); check("free_run1", bus.pc, 32'h3004);
    tick(); check("free_run2", bus.pc, 32'h3008);
    tick(); check("free_run3", bus.pc, 32'h300C);

    // beq taken backwards: 0x3004 + 4 - 8 = 0x3000
    drive_branch(3'b000, 32'h3004, 16'hFFFE, 32'd5, 32'd5);
    #1;
    check("beq_taken", {31'd0, bus.taken}, 32'd1);
    check("beq_link", bus.link_pc, 32'h300C);
    tick(); check("beq_pc", bus.pc, 32'h3000);
    bus.rt_val = 32'd6;
    #1;
    check("beq_not_taken", {31'd0, bus.taken}, 32'd0);
    tick(); check("beq_nt_pc", bus.pc, 32'h3004);

    cmp_taken("lez_neg", 3'b010, 32'h8000_0000, 1'b1);
    cmp_taken("gtz_neg", 3'b011, 32'h8000_0000, 1'b0);
    cmp_taken("ltz_neg", 3'b100, 32'h8000_0000, 1'b1);
    cmp_taken("gez_neg", 3'b101, 32'h8000_0000, 1'b0);
    cmp_taken("lez_zero", 3'b010, 32'd0, 1'b1);
    cmp_taken("gtz_zero", 3'b011, 32'd0, 1'b0);
    cmp_taken("ltz_zero", 3'b100, 32'd0, 1'b0);
    cmp_taken("gez_zero", 3'b101, 32'd0, 1'b1);
    cmp_taken("gtz_pos", 3'b011, 32'd5, 1'b1);
    cmp_taken("bne_diff", 3'b001, 32'd7, 1'b1);
    cmp_taken("mode_never", 3'b110, 32'd0, 1'b0);

    // j: {0x0, 0xC10, 00} = 0x3040
    drive_idle();
    bus.npc_op = 3'b010;
    bus.d_pc   = 32'h3010;
    bus.imm26  = 26'h000_0C10;
    #1;
    check("j_taken", {31'd0, bus.taken}, 32'd1);
    check("j_link", bus.link_pc, 32'h3018);
    tick(); check("j_pc", bus.pc, 32'h3040);

    drive_idle();
    bus.npc_op = 3'b011;
    bus.rs_val = 32'h3002;
    tick();
    check("jr_pc", bus.pc, 32'h3002);
    check("jr_mis", {31'd0, bus.pc_misaligned}, 32'd1);

    // Stalled branch must hold pc, then redirect once stall drops
    drive_idle();
    drive_branch(3'b000, 32'h3004, 16'hFFFE, 32'd1, 32'd1);
    bus.stall = 1'b1;
    tick(); check("stall_hold1", bus.pc, 32'h3002);
    tick(); check("stall_hold2", bus.pc, 32'h3002);
    bus.stall = 1'b0;
    tick();
    check("stall_release", bus.pc, 32'h3000);
    check("stall_rel_mis", {31'd0, bus.pc_misaligned}, 32'd0);

    drive_idle();
    bus.exc_req = 1'b1;
    bus.eret    = 1'b1;
    bus.stall   = 1'b1;
    tick(); check("exc_priority", bus.pc, 32'h4180);
    drive_idle();
    bus.eret = 1'b1;
    bus.epc  = 32'h3020;
    tick(); check("eret_pc", bus.pc, 32'h3020);

    drive_idle();
    drive_branch(3'b000, 32'h3004, 16'h0010, 32'd2, 32'd2);
    reset = 1'b1;
    tick(); check("reset_mid_branch", bus.pc, 32'h3000);
    reset = 1'b0;
    drive_idle();
    tick(); check("after_reset", bus.pc, 32'h3004);

    bus.npc_op = 3'b011;
    bus.rs_val = 32'hFFFF_FFFC;
    tick(); check("jr_top", bus.pc, 32'hFFFF_FFFC);
    drive_idle();
    tick(); check("pc_wrap", bus.pc, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_pipe.md
Name: npc_pipe

Overview:
- Fetch-stage program-counter unit for the pipelined MIPS core: holds the F-stage PC register and computes the next PC every cycle.
- Resolves branch and jump redirects from the D stage with delayed-branch semantics.
- Supports extended branch compare modes, stall hold, exception-vector entry and ERET return.
- Sits between the instruction memory address port and the D-stage comparator and control.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
EXC_VECTOR, 32'h0000_4180, PC loaded on exception entry.
ENABLE_EXC, 1, when 0: exc_req and eret are ignored and treated as 0.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hazard stall; holds the PC.
npc_op  input  3  000 sequential, 001 conditional branch, 010 j/jal, 011 jr/jalr, others sequential.
cmp_mode  input  3  000 eq, 001 ne, 010 lez, 011 gtz, 100 ltz, 101 gez, others never-taken.
d_pc  input  32  PC of the branch or jump instruction currently in D.
imm26  input  26  instruction immediate field; bits [15:0] are the branch offset.
rs_val  input  32  forwarded rs value.
rt_val  input  32  forwarded rt value.
exc_req  input  1  exception or interrupt entry request.
eret  input  1  ERET in D.
epc  input  32  return address for ERET.
pc  output  32  current F-stage PC (registered).
link_pc  output  32  d_pc+8, the link value for jal/jalr.
taken  output  1  combinational: D-stage redirect is active this cycle.
pc_misaligned  output  1  registered: pc[1:0] != 0.

Behaviour:
- Reset (synchronous, clk edge with reset=1): pc <= RESET_PC; pc_misaligned <= (RESET_PC[1:0]!=0).
- Outputs during reset:
  - taken is combinational and follows its inputs.
  - link_pc is combinational and equals d_pc+8.
- Branch condition, signed 32-bit compare:
  - eq: rs==rt
  - ne: rs!=rt
  - lez: rs<=0
  - gtz: rs>0
  - ltz: rs[31]
  - gez: !rs[31]
- taken is asserted for:
  - npc_op=001 when the condition holds;
  - npc_op=010;
  - npc_op=011.
- Targets use 32-bit wrap-around arithmetic; no overflow flag:
  - branch: d_pc + 4 + {{14{imm26[15]}}, imm26[15:0], 2'b00}
  - j: {d_pc_plus4[31:28], imm26, 2'b00}, where d_pc_plus4 = d_pc+4
  - jr: rs_val, unmodified; misaligned targets are allowed
- Next-PC priority per clk edge, highest first:
  1. reset
  2. exc_req -> EXC_VECTOR
  3. eret -> epc
  4. stall -> pc holds
  5. taken -> target
  6. otherwise pc+4
- Latency:
  - A redirect appears on pc exactly one cycle after taken is sampled.
  - The instruction fetched in the same cycle as the branch sits in D, i.e. the delay slot, and is always executed.
- Stall:
  - Redirects are dropped while stall=1. D is held too, so the branch re-presents taken next cycle.
  - Stall does not block exc_req or eret.
- exc_req and eret both high: exc_req wins.
- pc_misaligned is registered alongside pc and reflects the new pc value in the same cycle.
- pc+4 at 32'hFFFF_FFFC wraps to 0.
- With ENABLE_EXC=0, pc ignores epc entirely.

Test Plan:
- Reset, then 3 free-run cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C.
- d_pc=0x3004, npc_op=001, cmp_mode=000, rs=rt=5, imm16=0xFFFE -> taken=1; next pc = 0x3000. Same with rt=6 -> taken=0; pc = previous pc+4.
- cmp_mode sweep with rs=0x80000000: lez=1, gtz=0, ltz=1, gez=0; rs=0: lez=1, gtz=0, ltz=0, gez=1.
- npc_op=010, d_pc=0x3010, imm26=0x0000C10 -> next pc = 0x3040, link_pc = 0x3018. npc_op=011, rs=0x3002 -> pc = 0x3002, pc_misaligned=1 in the same cycle.
- stall=1 with taken=1 for 2 cycles -> pc holds. Then stall=0 -> pc = target the next cycle.
- exc_req=1 together with eret=1 and stall=1 -> pc = 0x4180. Next cycle eret=1, epc=0x3020 -> pc = 0x3020. reset=1 mid-branch -> pc = 0x3000.
